// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer: the FSM state
// encoding, the instruction width and the sequential PC increment.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ILEN    = 32;  // instruction word width
    localparam int PC_STEP = 4;   // byte distance between sequential instructions

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,  // single cycle after reset
        ST_REQ     = 3'd1,  // instruction-memory request outstanding
        ST_DELIVER = 3'd2,  // instruction presented to execute
        ST_HALT    = 3'd3,  // stopped by halt, terminal until reset
        ST_TRAP    = 3'd4   // stopped by misaligned redirect, terminal until reset
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/next_pc_gen.sv
// -----------------------------------------------------------------------------
// next_pc_gen
// Purely combinational next-PC selection for the fetch sequencer.
//
// Ports:
//   pc          in  XLEN  current program counter
//   jump_flag   in  1     taken branch / jump
//   jalr        in  1     register-based target; bit 0 of the target is cleared
//   jump_target in  XLEN  redirect target
//   next_pc     out XLEN  redirect target when jumping, else pc + PC_STEP
//   misaligned  out 1     jumping to a target whose bits [1:0] are non-zero
// -----------------------------------------------------------------------------
module next_pc_gen
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            jump_flag,
    input  logic            jalr,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] target;

    // A register-based target drops bit 0 before the alignment check, so an
    // odd jalr target that is otherwise word aligned is still legal.
    assign target     = jalr ? {jump_target[XLEN-1:1], 1'b0} : jump_target;
    assign next_pc    = jump_flag ? target : pc + XLEN'(PC_STEP);
    assign misaligned = jump_flag && (target[1:0] != 2'b00);

endmodule : next_pc_gen

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch sequencer: owns the PC, issues one instruction-memory
// request at a time, presents the returned word to execute and advances the
// PC (sequential or redirect) when execute accepts it. Also tracks halt,
// misaligned-redirect trap and retired-instruction count.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   imem_req/addr    out  fetch request and address (addr = pc)
//   imem_ack/rdata   in   memory response and instruction word
//   inst_valid/inst/inst_pc  out  instruction presented to execute
//   inst_ready       in   execute accepts inst this cycle
//   jump_flag, jalr, jump_target, halt  in  control qualified by accept
//   halted           out  sequencer stopped by halt
//   misalign_trap    out  sticky trap flag; trap_pc holds the bad target
//   retire_cnt       out  accepted-instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            jump_flag,
    input  logic            jalr,
    input  logic [XLEN-1:0] jump_target,
    input  logic            halt,
    output logic            halted,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     retire_cnt
);

    fetch_state_e    state_q,   state_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [ILEN-1:0] inst_q,    inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            trap_q,    trap_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic [31:0]     retire_q,  retire_d;

    logic [XLEN-1:0] npc;
    logic            npc_misaligned;

    next_pc_gen #(
        .XLEN(XLEN)
    ) u_next_pc_gen (
        .pc          (pc_q),
        .jump_flag   (jump_flag),
        .jalr        (jalr),
        .jump_target (jump_target),
        .next_pc     (npc),
        .misaligned  (npc_misaligned)
    );

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        retire_d  = retire_q;

        unique case (state_q)
            ST_BOOT: state_d = ST_REQ;

            ST_REQ: begin
                if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = ST_DELIVER;
                end
            end

            ST_DELIVER: begin
                if (inst_ready) begin
                    retire_d = retire_q + 32'd1;
                    // halt wins over both redirect and trap.
                    if (halt) begin
                        pc_d    = pc_q + XLEN'(PC_STEP);
                        state_d = ST_HALT;
                    end else if (npc_misaligned) begin
                        // npc carries the (jalr-adjusted) target when jumping.
                        trap_d    = 1'b1;
                        trap_pc_d = npc;
                        state_d   = ST_TRAP;
                    end else begin
                        pc_d    = npc;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_HALT, ST_TRAP: state_d = state_q;

            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and all
        // state uses non-blocking assignments so every register updates from
        // the pre-edge values.
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
            retire_q  <= retire_d;
        end
    end

    // Handshake outputs decode the state register only: no input-to-output path.
    assign imem_req      = (state_q == ST_REQ);
    assign inst_valid    = (state_q == ST_DELIVER);
    assign halted        = (state_q == ST_HALT);
    assign imem_addr     = pc_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign misalign_trap = trap_q;
    assign trap_pc       = trap_pc_q;
    assign retire_cnt    = retire_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed self-checking bench for fetch_sequencer (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            jump_flag;
    logic            jalr;
    logic [XLEN-1:0] jump_target;
    logic            halt;
    logic            halted;
    logic            misalign_trap;
    logic [XLEN-1:0] trap_pc;
    logic [31:0]     retire_cnt;

    logic            rdata_auto;
    logic [31:0]     rdata_man;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Memory model: in auto mode the word encodes its own address.
    assign imem_rdata = rdata_auto ? (32'hC0DE_0000 | {16'h0, imem_addr[15:0]}) : rdata_man;

    fetch_sequencer #(
        .XLEN     (XLEN),
        .RESET_PC ('0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .jump_flag     (jump_flag),
        .jalr          (jalr),
        .jump_target   (jump_target),
        .halt          (halt),
        .halted        (halted),
        .misalign_trap (misalign_trap),
        .trap_pc       (trap_pc),
        .retire_cnt    (retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        jump_flag   = 1'b0;
        jalr        = 1'b0;
        jump_target = '0;
        halt        = 1'b0;
        rdata_auto  = 1'b1;
        rdata_man   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for the first request after reset release.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!imem_req && n < 4) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, 32'(imem_req), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset values ----------------
        do_reset();
        check("rst_req",      32'(imem_req),      32'd0);
        check("rst_valid",    32'(inst_valid),    32'd0);
        check("rst_halted",   32'(halted),        32'd0);
        check("rst_trap",     32'(misalign_trap), 32'd0);
        check("rst_addr",     imem_addr,          32'h0);
        check("rst_inst",     inst,               32'h0);
        check("rst_inst_pc",  inst_pc,            32'h0);
        check("rst_trap_pc",  trap_pc,            32'h0);
        check("rst_retire",   retire_cnt,         32'd0);

        // ---------------- streaming: ack and ready tied high ----------------
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        wait_req("stream");
        for (int i = 0; i < 3; i++) begin
            check("stream_addr",    imem_addr, 32'(4 * i));
            step();
            check("stream_valid",   32'(inst_valid), 32'd1);
            check("stream_req_lo",  32'(imem_req),   32'd0);
            check("stream_inst",    inst,    32'hC0DE_0000 | 32'(4 * i));
            check("stream_inst_pc", inst_pc, 32'(4 * i));
            step();
        end
        check("stream_retire", retire_cnt, 32'd3);
        check("stream_next",   imem_addr,  32'hC);

        // ---------------- delayed ack at 0x4, then jump at 0x10 ----------------
        do_reset();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        wait_req("delay");
        step();                 // DELIVER pc 0
        step();                 // REQ pc 4
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("delay_req_hold",  32'(imem_req), 32'd1);
            check("delay_addr_hold", imem_addr,     32'h4);
            step();
        end
        imem_ack   = 1'b1;
        rdata_auto = 1'b0;
        rdata_man  = 32'hDEAD_BEEF;
        step();                 // DELIVER pc 4
        rdata_man  = 32'h1234_5678;   // must not disturb the captured word
        check("delay_inst",    inst,    32'hDEAD_BEEF);
        check("delay_inst_pc", inst_pc, 32'h4);
        step();                 // ready low: presentation held
        check("delay_hold_valid", 32'(inst_valid), 32'd1);
        check("delay_hold_inst",  inst,            32'hDEAD_BEEF);
        rdata_auto = 1'b1;
        inst_ready = 1'b1;
        step();                 // REQ 8
        step();                 // DELIVER 8
        step();                 // REQ C
        step();                 // DELIVER C
        step();                 // REQ 10
        step();                 // DELIVER 10
        check("jump_at_pc", inst_pc, 32'h10);
        jump_flag   = 1'b1;
        jump_target = 32'h40;
        step();
        jump_flag   = 1'b0;
        check("jump_req",    32'(imem_req), 32'd1);
        check("jump_addr",   imem_addr,     32'h40);
        check("jump_retire", retire_cnt,    32'd5);

        // ---------------- jalr bit-0 clear, then misaligned trap ----------------
        step();                 // DELIVER 0x40
        jump_flag   = 1'b1;
        jalr        = 1'b1;
        jump_target = 32'h41;
        step();
        check("jalr_req",  32'(imem_req), 32'd1);
        check("jalr_addr", imem_addr,     32'h40);
        check("jalr_no_trap", 32'(misalign_trap), 32'd0);
        jump_flag   = 1'b0;
        step();                 // DELIVER 0x40
        jump_flag   = 1'b1;
        jump_target = 32'h42;
        step();
        jump_flag   = 1'b0;
        jalr        = 1'b0;
        check("trap_flag",   32'(misalign_trap), 32'd1);
        check("trap_pc",     trap_pc,            32'h42);
        check("trap_retire", retire_cnt,         32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("trap_req_lo",  32'(imem_req),      32'd0);
            check("trap_valid_lo",32'(inst_valid),    32'd0);
            check("trap_sticky",  32'(misalign_trap), 32'd1);
        end
        check("trap_pc_kept", imem_addr, 32'h40);

        // ---------------- halt beats jump and trap ----------------
        do_reset();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        wait_req("halt");
        step();                 // DELIVER pc 0
        halt        = 1'b1;
        jump_flag   = 1'b1;
        jump_target = 32'h42;
        step();
        halt        = 1'b0;
        jump_flag   = 1'b0;
        check("halt_halted",  32'(halted),        32'd1);
        check("halt_no_trap", 32'(misalign_trap), 32'd0);
        check("halt_pc",      imem_addr,          32'h4);
        check("halt_retire",  retire_cnt,         32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_req_lo", 32'(imem_req), 32'd0);
            check("halt_stays",  32'(halted),   32'd1);
        end

        // ---------------- reset during an outstanding request ----------------
        do_reset();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        wait_req("mid");
        step();                 // DELIVER 0
        step();                 // REQ 4
        step();                 // DELIVER 4
        step();                 // REQ 8
        imem_ack = 1'b0;
        check("mid_pre_addr", imem_addr, 32'h8);
        rst_n = 1'b0;
        step();
        check("mid_req_lo",  32'(imem_req), 32'd0);
        check("mid_pc",      imem_addr,     32'h0);
        check("mid_retire",  retire_cnt,    32'd0);
        check("mid_inst",    inst,          32'h0);
        rst_n    = 1'b1;
        imem_ack = 1'b1;        // late ack while in BOOT
        step();
        imem_ack = 1'b0;
        check("mid_boot_ack_ignored", 32'(inst_valid), 32'd0);
        check("mid_restart_req",      32'(imem_req),   32'd1);
        check("mid_restart_addr",     imem_addr,       32'h0);
        step();
        check("mid_req_waits", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        step();
        check("mid_deliver",  32'(inst_valid), 32'd1);
        check("mid_inst_pc",  inst_pc,         32'h0);
        check("mid_inst_new", inst,            32'hC0DE_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
